// File: rtl/hazard_ctrl.sv
// Hazard controller for the bluex core: ID/EX forwarding selects plus stage
// clock enables / bubbles for load-use stalls, branch flushes and MDU occupancy.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int GPR_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [GPR_W-1:0] id_rs_addr,
  input  logic [GPR_W-1:0] id_rt_addr,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_is_mdu,
  input  logic [GPR_W-1:0] ex_write_reg_addr,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [GPR_W-1:0] mem_write_reg_addr,
  input  logic             mem_reg_write,
  input  logic             ex_branch_taken,
  output logic [1:0]       rs_forward,
  output logic [1:0]       rt_forward,
  output logic             pc_cen,
  output logic             ifid_cen,
  output logic             idex_cen,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_bubble,
  output logic             mdu_busy
);

  localparam logic [1:0] RSF_RSF = 2'b00;
  localparam logic [1:0] RSF_WBD = 2'b01;
  localparam logic [1:0] RSF_ALU = 2'b10;
  localparam logic [1:0] RTF_RTF = 2'b00;
  localparam logic [1:0] RTF_WBD = 2'b01;
  localparam logic [1:0] RTF_ALU = 2'b10;

  localparam int             CNT_W    = $clog2(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 2);

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;

  // EX match wins over MEM match; $0 is hard-wired and never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic             used,
    input logic [GPR_W-1:0] addr,
    input logic [1:0]       code_alu,
    input logic [1:0]       code_wbd,
    input logic [1:0]       code_reg
  );
    logic [1:0] sel;
    sel = code_reg;
    if (used && (addr != '0)) begin
      if (ex_reg_write && !ex_mem_to_reg && (ex_write_reg_addr == addr))
        sel = code_alu;
      else if (mem_reg_write && (mem_write_reg_addr == addr))
        sel = code_wbd;
    end
    return sel;
  endfunction

  always_comb begin
    rs_forward = fwd_sel(id_rs_used, id_rs_addr, RSF_ALU, RSF_WBD, RSF_RSF);
    rt_forward = fwd_sel(id_rt_used, id_rt_addr, RTF_ALU, RTF_WBD, RTF_RTF);
  end

  assign lu = ex_reg_write && ex_mem_to_reg && (ex_write_reg_addr != '0) &&
              ((id_rs_used && (id_rs_addr == ex_write_reg_addr)) ||
               (id_rt_used && (id_rt_addr == ex_write_reg_addr)));

  // State register: reset aborts any MDU sequence immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_cen       = 1'b1;
    ifid_cen     = 1'b1;
    idex_cen     = 1'b1;
    idex_bubble  = 1'b0;
    ifid_flush   = 1'b0;
    exmem_bubble = 1'b0;
    mdu_busy     = 1'b0;
    if (rst) begin
      unique case (state)
        RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (lu) begin
            pc_cen      = 1'b0;
            ifid_cen    = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_is_mdu) begin
            state_nxt = MDU;
            cnt_nxt   = CNT_LOAD;
          end
        end
        MDU: begin
          // EX holds the MDU op; branch and load-use inputs are meaningless here.
          pc_cen       = 1'b0;
          ifid_cen     = 1'b0;
          idex_cen     = 1'b0;
          exmem_bubble = 1'b1;
          mdu_busy     = 1'b1;
          if (cnt == '0)
            state_nxt = RUN;
          else
            cnt_nxt = cnt - CNT_W'(1);
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against an occupancy-count model.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, ex_write_reg_addr, mem_write_reg_addr;
  logic       id_rs_used, id_rt_used, id_is_mdu;
  logic       ex_reg_write, ex_mem_to_reg, mem_reg_write, ex_branch_taken;
  logic [1:0] rs_forward, rt_forward;
  logic       pc_cen, ifid_cen, idex_cen, idex_bubble, ifid_flush, exmem_bubble, mdu_busy;

  int n_chk = 0;
  int n_err = 0;

  // Model: number of further cycles EX stays occupied by an accepted MDU op.
  int rem = 0;
  logic [1:0] e_rsf, e_rtf;
  logic       e_pc, e_ifid, e_idex, e_idb, e_flush, e_exb, e_busy, m_lu;

  hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_is_mdu(id_is_mdu),
    .ex_write_reg_addr(ex_write_reg_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .mem_write_reg_addr(mem_write_reg_addr),
    .mem_reg_write(mem_reg_write), .ex_branch_taken(ex_branch_taken),
    .rs_forward(rs_forward), .rt_forward(rt_forward),
    .pc_cen(pc_cen), .ifid_cen(ifid_cen), .idex_cen(idex_cen),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
    .exmem_bubble(exmem_bubble), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] ref_fwd(input logic used, input logic [4:0] a);
    if (!used || a == 0) return 2'b00;
    if (ex_reg_write && !ex_mem_to_reg && ex_write_reg_addr == a) return 2'b10;
    if (mem_reg_write && mem_write_reg_addr == a) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_outputs();
    if (!rst) rem = 0;
    e_rsf = ref_fwd(id_rs_used, id_rs_addr);
    e_rtf = ref_fwd(id_rt_used, id_rt_addr);
    m_lu  = ex_reg_write && ex_mem_to_reg && ex_write_reg_addr != 0 &&
            ((id_rs_used && id_rs_addr == ex_write_reg_addr) ||
             (id_rt_used && id_rt_addr == ex_write_reg_addr));
    {e_pc, e_ifid, e_idex} = 3'b111;
    {e_idb, e_flush, e_exb, e_busy} = 4'b0000;
    if (rst) begin
      if (rem > 0) begin
        {e_pc, e_ifid, e_idex} = 3'b000;
        e_exb  = 1'b1;
        e_busy = 1'b1;
      end else if (ex_branch_taken) begin
        e_flush = 1'b1;
        e_idb   = 1'b1;
      end else if (m_lu) begin
        e_pc  = 1'b0;
        e_ifid = 1'b0;
        e_idb = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle_check(input string tag);
    #2;
    model_outputs();
    chk({tag, ".rs_forward"}, rs_forward, e_rsf);
    chk({tag, ".rt_forward"}, rt_forward, e_rtf);
    chk({tag, ".pc_cen"}, {1'b0, pc_cen}, {1'b0, e_pc});
    chk({tag, ".ifid_cen"}, {1'b0, ifid_cen}, {1'b0, e_ifid});
    chk({tag, ".idex_cen"}, {1'b0, idex_cen}, {1'b0, e_idex});
    chk({tag, ".idex_bubble"}, {1'b0, idex_bubble}, {1'b0, e_idb});
    chk({tag, ".ifid_flush"}, {1'b0, ifid_flush}, {1'b0, e_flush});
    chk({tag, ".exmem_bubble"}, {1'b0, exmem_bubble}, {1'b0, e_exb});
    chk({tag, ".mdu_busy"}, {1'b0, mdu_busy}, {1'b0, e_busy});
  endtask

  task automatic advance();
    @(posedge clk);
    model_outputs();
    if (!rst) rem = 0;
    else if (rem > 0) rem--;
    else if (!ex_branch_taken && !m_lu && id_is_mdu) rem = MDU_LAT - 1;
    #1;
  endtask

  task automatic clear_inputs();
    id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0; id_is_mdu = 0;
    ex_write_reg_addr = 0; ex_reg_write = 0; ex_mem_to_reg = 0;
    mem_write_reg_addr = 0; mem_reg_write = 0; ex_branch_taken = 0;
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    // Reset state, with an active load-use pattern that must be masked.
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg_addr = 2;
    id_rs_used = 1; id_rs_addr = 2;
    settle_check("reset");
    chk("reset.pc_cen", {1'b0, pc_cen}, 2'b01);
    chk("reset.mdu_busy", {1'b0, mdu_busy}, 2'b00);
    advance();
    advance();
    rst = 1'b1;
    clear_inputs();
    settle_check("idle");
    advance();

    // ALU forward on both sources.
    ex_reg_write = 1; ex_write_reg_addr = 5;
    id_rs_used = 1; id_rt_used = 1; id_rs_addr = 5; id_rt_addr = 5;
    settle_check("alu_fwd");
    chk("alu_fwd.rs", rs_forward, 2'b10);
    chk("alu_fwd.rt", rt_forward, 2'b10);
    chk("alu_fwd.pc_cen", {1'b0, pc_cen}, 2'b01);
    advance();

    // EX beats MEM; $0 never forwards; MEM-only match gives WBD.
    clear_inputs();
    ex_reg_write = 1; ex_write_reg_addr = 7; mem_reg_write = 1; mem_write_reg_addr = 7;
    id_rs_used = 1; id_rs_addr = 7;
    settle_check("prio");
    chk("prio.rs", rs_forward, 2'b10);
    advance();
    ex_write_reg_addr = 0; mem_write_reg_addr = 0; id_rs_addr = 0;
    settle_check("zero");
    chk("zero.rs", rs_forward, 2'b00);
    advance();
    ex_write_reg_addr = 3; mem_write_reg_addr = 7; id_rs_used = 0;
    id_rt_used = 1; id_rt_addr = 7;
    settle_check("wbd");
    chk("wbd.rt", rt_forward, 2'b01);
    advance();

    // Load-use: one stall cycle, then WBD forward.
    clear_inputs();
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg_addr = 9;
    id_rt_used = 1; id_rt_addr = 9;
    settle_check("lu0");
    chk("lu0.pc_cen", {1'b0, pc_cen}, 2'b00);
    chk("lu0.ifid_cen", {1'b0, ifid_cen}, 2'b00);
    chk("lu0.idex_bubble", {1'b0, idex_bubble}, 2'b01);
    advance();
    ex_reg_write = 0; ex_mem_to_reg = 0; ex_write_reg_addr = 0;
    mem_reg_write = 1; mem_write_reg_addr = 9;
    settle_check("lu1");
    chk("lu1.rt", rt_forward, 2'b01);
    chk("lu1.pc_cen", {1'b0, pc_cen}, 2'b01);
    advance();

    // MDU sequencing: three held cycles after acceptance.
    clear_inputs();
    id_is_mdu = 1;
    settle_check("mdu_acc");
    chk("mdu_acc.idex_cen", {1'b0, idex_cen}, 2'b01);
    advance();
    id_is_mdu = 0;
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      settle_check("mdu_hold");
      chk("mdu_hold.busy", {1'b0, mdu_busy}, 2'b01);
      chk("mdu_hold.idex_cen", {1'b0, idex_cen}, 2'b00);
      chk("mdu_hold.exmem_bubble", {1'b0, exmem_bubble}, 2'b01);
      advance();
    end
    settle_check("mdu_done");
    chk("mdu_done.busy", {1'b0, mdu_busy}, 2'b00);
    chk("mdu_done.idex_cen", {1'b0, idex_cen}, 2'b01);
    advance();

    // Flush beats MDU acceptance and load-use.
    ex_branch_taken = 1; id_is_mdu = 1;
    ex_reg_write = 1; ex_mem_to_reg = 1; ex_write_reg_addr = 4;
    id_rs_used = 1; id_rs_addr = 4;
    settle_check("flush");
    chk("flush.ifid_flush", {1'b0, ifid_flush}, 2'b01);
    chk("flush.idex_bubble", {1'b0, idex_bubble}, 2'b01);
    chk("flush.pc_cen", {1'b0, pc_cen}, 2'b01);
    advance();
    clear_inputs();
    settle_check("flush_next");
    chk("flush_next.busy", {1'b0, mdu_busy}, 2'b00);
    advance();

    // Reset two cycles into an MDU sequence, then a fresh full sequence.
    id_is_mdu = 1;
    settle_check("rmdu_acc");
    advance();
    id_is_mdu = 0;
    settle_check("rmdu_h1");
    advance();
    settle_check("rmdu_h2");
    advance();
    rst = 1'b0;
    settle_check("rmdu_rst");
    chk("rmdu_rst.busy", {1'b0, mdu_busy}, 2'b00);
    chk("rmdu_rst.idex_cen", {1'b0, idex_cen}, 2'b01);
    chk("rmdu_rst.pc_cen", {1'b0, pc_cen}, 2'b01);
    advance();
    rst = 1'b1;
    id_is_mdu = 1;
    settle_check("rmdu_acc2");
    advance();
    id_is_mdu = 0;
    for (int i = 0; i < MDU_LAT - 1; i++) begin
      settle_check("rmdu_hold2");
      chk("rmdu_hold2.busy", {1'b0, mdu_busy}, 2'b01);
      advance();
    end
    settle_check("rmdu_done2");
    chk("rmdu_done2.busy", {1'b0, mdu_busy}, 2'b00);
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst                = ($urandom_range(0, 59) != 0);
      id_rs_addr         = 5'($urandom_range(0, 3));
      id_rt_addr         = 5'($urandom_range(0, 3));
      id_rs_used         = 1'($urandom_range(0, 1));
      id_rt_used         = 1'($urandom_range(0, 1));
      id_is_mdu          = ($urandom_range(0, 5) == 0);
      ex_write_reg_addr  = 5'($urandom_range(0, 3));
      ex_reg_write       = 1'($urandom_range(0, 1));
      ex_mem_to_reg      = 1'($urandom_range(0, 1));
      mem_write_reg_addr = 5'($urandom_range(0, 3));
      mem_reg_write      = 1'($urandom_range(0, 1));
      ex_branch_taken    = ($urandom_range(0, 7) == 0);
      settle_check("rand");
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the bluex core. It owns the ID/EX forwarding selects and the clock enables that the ID/EX stage register consumes. It also sequences the surrounding stage registers through load-use stalls, taken-branch flushes and multi-cycle MDU (mul/div) occupancy of EX. It sits beside the ID stage, with its outputs feeding the PC register, the IF/ID register, the ID/EX register and the EX/MEM register.

## Interface

Parameters:
- `MDU_LAT`, default 4: cycles an MDU op occupies EX. Legal range is 2..16.

Ports:
- `clk` input 1: clock. Everything is sampled on the rising edge.
- `rst` input 1: asynchronous, active-low reset. The block has one clock; reset is asynchronous and active-low.
- `id_rs_addr`, `id_rt_addr` input `GPR_ADR`: source register addresses of the instruction in ID.
- `id_rs_used`, `id_rt_used` input 1: the instruction in ID actually reads rs / rt.
- `id_is_mdu` input 1: the instruction in ID is an MDU op.
- `ex_write_reg_addr` input `GPR_ADR`: destination register of the instruction in EX.
- `ex_reg_write`, `ex_mem_to_reg` input 1: control bits of the instruction in EX.
- `mem_write_reg_addr` input `GPR_ADR`: destination register of the instruction in MEM.
- `mem_reg_write` input 1: write-enable of the instruction in MEM.
- `ex_branch_taken` input 1: the branch in EX resolved taken this cycle.
- `rs_forward`, `rt_forward` output 2: forwarding selects, registered into ID/EX. Encodings are `RSF_RSF`/`RTF_RTF`=2'b00, `RSF_WBD`/`RTF_WBD`=2'b01, `RSF_ALU`/`RTF_ALU`=2'b10.
- `pc_cen`, `ifid_cen`, `idex_cen` output 1: stage-register clock enables.
- `idex_bubble` output 1: zeroes `reg_write`/`mem_write`/`mem_to_reg`/`branch_isc` going into ID/EX.
- `ifid_flush` output 1: loads a NOP into IF/ID.
- `exmem_bubble` output 1: zeroes the control bits entering EX/MEM.
- `mdu_busy` output 1: high while the FSM is in MDU.

## Operation

**Forwarding (combinational, per source; rt identical with the RTF codes)**
- `RSF_ALU` if `id_rs_used`, `ex_reg_write`, `!ex_mem_to_reg`, `ex_write_reg_addr==id_rs_addr` and `id_rs_addr!=0`.
- Otherwise `RSF_WBD` if `id_rs_used`, `mem_reg_write`, `mem_write_reg_addr==id_rs_addr` and `id_rs_addr!=0`.
- Otherwise `RSF_RSF`.
- The EX match has priority over the MEM match.
- Register 0 never forwards.

**Load-use detection**
- `lu` = `ex_reg_write & ex_mem_to_reg & (ex_write_reg_addr!=0)`, and that address matches a used `id_rs_addr` or `id_rt_addr`.

**FSM states:** RUN, MDU. A counter `cnt` of `$clog2(MDU_LAT)` bits runs only in MDU.

**RUN, priority order:**
1. `ex_branch_taken`: `ifid_flush=1`, `idex_bubble=1`, all cens 1. Stay in RUN. `id_is_mdu` and `lu` are ignored because the ID instruction is squashed.
2. `lu`: `pc_cen=0`, `ifid_cen=0`, `idex_cen=1`, `idex_bubble=1`. Stay in RUN. The next cycle the load is in MEM, so the forward resolves to WBD.
3. `id_is_mdu`: all cens 1 and the op enters EX. Next state is MDU with `cnt=MDU_LAT-2`.
4. Otherwise all cens 1 and all bubble/flush outputs 0.

**MDU:**
- `pc_cen=ifid_cen=idex_cen=0`, `exmem_bubble=1`, `mdu_busy=1`.
- Forwarding outputs are still computed but are not captured, because `idex_cen=0`.
- If `cnt==0`, the next state is RUN; otherwise `cnt` decrements.
- The MDU op therefore occupies EX for exactly `MDU_LAT` cycles: 1 entry cycle plus `MDU_LAT-1` held cycles.
- `ex_branch_taken` and `lu` cannot occur in MDU, since EX holds the MDU op. If they are asserted they are ignored.

**Defaults:** every output not named above is 0, and every cen not named is 1.

## Timing

- **Reset:** `rst` low asynchronously forces state RUN and `cnt=0`.
  - During reset: `pc_cen=ifid_cen=idex_cen=1`; `idex_bubble`, `ifid_flush`, `exmem_bubble` and `mdu_busy` are 0; `rs_forward`/`rt_forward` follow their combinational rule.
  - Reset asserted mid-MDU aborts the sequence immediately.
  - The first edge after reset release runs in RUN.
- **Latency:**
  - Forwarding, load-use and flush outputs are combinational from the current inputs and state, valid the same cycle.
  - State and `cnt` update on the rising edge.
  - `mdu_busy` rises the cycle after the MDU op is accepted into EX.
- **Stall lengths:** load-use stalls IF/ID for exactly 1 cycle per hazard. A back-to-back load-use (load, then dependent load, then dependent op) stalls 1 cycle each.
- **`MDU_LAT=2`:** MDU state lasts 1 cycle (`cnt` loaded with 0).
- **Simultaneous events:** flush has priority over MDU acceptance and over load-use.

## Test plan

- **ALU forward.** EX: `ex_reg_write=1`, `ex_mem_to_reg=0`, `ex_write_reg_addr=5`. ID: rs=5, rt=5, both used. Required: `rs_forward=2'b10`, `rt_forward=2'b10`, no stall.
- **Priority and $0.** EX dest 7 (ALU) and MEM dest 7 (`mem_reg_write=1`), ID rs=7 → `RSF_ALU`. Repeat with ID rs=0 and both dests 0 → `RSF_RSF`. EX dest 3, MEM dest 7, ID rt=7 → `RTF_WBD`.
- **Load-use.** EX load to r9, ID uses rt=9. Cycle 0: `pc_cen=0`, `ifid_cen=0`, `idex_bubble=1`. Cycle 1: the load moves to MEM and `rt_forward=2'b01`, `pc_cen=1`.
- **MDU sequencing, `MDU_LAT=4`.** Assert `id_is_mdu` for 1 cycle. Required: `mdu_busy=1` and `idex_cen=0` for exactly 3 cycles starting the next cycle, with `exmem_bubble=1` in those cycles; then back to RUN with all cens 1.
- **Flush wins.** `ex_branch_taken=1` with `id_is_mdu=1` and a load-use match in the same cycle. Required: `ifid_flush=1`, `idex_bubble=1`, `pc_cen=1`, and `mdu_busy` stays 0 on the next cycle.
- **Reset mid-MDU.** Pull `rst` low 2 cycles into an MDU sequence. Required: `mdu_busy` drops to 0 and all cens go to 1 without waiting for a clock edge. After release, `id_is_mdu` starts a full 4-cycle sequence again.
